mul_and_checker: RTL and testbench

MUL_AND_CHECKER -- requirements
Module: mul_and_checker

---
 rtl/mul_and_pkg.sv | 21 ++
 rtl/mul_and_delay.sv | 46 ++++
 rtl/mul_and_checker.sv | 111 +++++++++++
 tb/tb_mul_and_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_and_pkg.sv
// Shared constants and the reference (a*b)&c computation for the
// mul_and checker.
package mul_and_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int LATENCY_MAX   = 8;
  localparam int CALC_W        = 64;

  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  // Callers zero-extend operands to CALC_W and keep only the low WIDTH bits,
  // which gives the product truncated to WIDTH before the AND with c.
  function automatic logic [CALC_W-1:0] calc_expected(
    input logic [CALC_W-1:0] op_a,
    input logic [CALC_W-1:0] op_b,
    input logic [CALC_W-1:0] op_c
  );
    return (op_a * op_b) & op_c;
  endfunction

endpackage

// File: rtl/mul_and_delay.sv
// Valid + data shift register of DEPTH stages; only the valid tags are
// cleared by reset, data stages free-run.
module mul_and_delay
  import mul_and_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mul_and_checker.sv
// Checks a pipelined (a*b)&c unit: the expected value rides a LATENCY-deep
// delay line and is compared with p when its valid tag emerges.
module mul_and_checker
  import mul_and_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] p,
  input  logic             clear,
  output logic             chk_valid,
  output logic             mismatch,
  output logic             sticky_err,
  output logic [15:0]      err_count,
  output logic [31:0]      chk_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  logic [WIDTH-1:0] exp_now;
  logic [WIDTH-1:0] exp_out;
  logic             chk_fire;
  logic             cmp_fail;

  logic             mismatch_q,  mismatch_d;
  logic             sticky_q,    sticky_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [31:0]      chk_count_q, chk_count_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;

  assign exp_now = WIDTH'(calc_expected(CALC_W'(a), CALC_W'(b), CALC_W'(c)));

  // The delay line is the only register after the multiply, so LATENCY is exact.
  mul_and_delay #(
    .WIDTH(WIDTH),
    .DEPTH(LATENCY)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (exp_now),
    .out_valid(chk_fire),
    .out_data (exp_out)
  );

  always_comb begin
    cmp_fail    = chk_fire && (p != exp_out);
    mismatch_d  = cmp_fail;
    sticky_d    = sticky_q;
    err_count_d = err_count_q;
    chk_count_d = chk_count_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    // A coincident comparison is dropped when clear is high; the pulse still reports it.
    if (clear) begin
      sticky_d    = 1'b0;
      err_count_d = '0;
      chk_count_d = '0;
      first_exp_d = '0;
      first_got_d = '0;
    end else begin
      if (chk_fire) begin
        chk_count_d = chk_count_q + 32'd1;
      end
      if (cmp_fail) begin
        if (err_count_q != ERR_SAT) begin
          err_count_d = err_count_q + 16'd1;
        end
        if (!sticky_q) begin
          first_exp_d = exp_out;
          first_got_d = p;
        end
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q  <= 1'b0;
      sticky_q    <= 1'b0;
      err_count_q <= '0;
      chk_count_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      mismatch_q  <= mismatch_d;
      sticky_q    <= sticky_d;
      err_count_q <= err_count_d;
      chk_count_q <= chk_count_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  assign chk_valid  = chk_fire;
  assign mismatch   = mismatch_q;
  assign sticky_err = sticky_q;
  assign err_count  = err_count_q;
  assign chk_count  = chk_count_q;
  assign first_exp  = first_exp_q;
  assign first_got  = first_got_q;

endmodule

// File: tb/tb_mul_and_checker.sv
// Directed bench for mul_and_checker: one instance at LATENCY=2 for the
// function/counter checks and one at LATENCY=3 for gap propagation.
module tb_mul_and_checker;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         clear;
  logic [W-1:0] a, b, c, p;

  logic         chk_valid_2, mismatch_2, sticky_2;
  logic [15:0]  err_count_2;
  logic [31:0]  chk_count_2;
  logic [W-1:0] first_exp_2, first_got_2;

  logic         chk_valid_3, mismatch_3, sticky_3;
  logic [15:0]  err_count_3;
  logic [31:0]  chk_count_3;
  logic [W-1:0] first_exp_3, first_got_3;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  mul_and_checker #(.WIDTH(W), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .p(p),
    .clear(clear), .chk_valid(chk_valid_2), .mismatch(mismatch_2),
    .sticky_err(sticky_2), .err_count(err_count_2), .chk_count(chk_count_2),
    .first_exp(first_exp_2), .first_got(first_got_2)
  );

  mul_and_checker #(.WIDTH(W), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .p(p),
    .clear(clear), .chk_valid(chk_valid_3), .mismatch(mismatch_3),
    .sticky_err(sticky_3), .err_count(err_count_3), .chk_count(chk_count_3),
    .first_exp(first_exp_3), .first_got(first_got_3)
  );

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] cv, input logic [W-1:0] pv);
    in_valid = v;
    a = av;
    b = bv;
    c = cv;
    p = pv;
  endtask

  task automatic doReset();
    rst   = 1'b1;
    clear = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Operands at cycle 0, result at cycle 2 (optionally with clear), returns at cycle 3.
  task automatic runOne(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv,
                        input logic [W-1:0] pv, input logic clr);
    applyStimulus(1'b1, av, bv, cv, '0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("chk_valid_c1", 32'(chk_valid_2), 32'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, pv);
    clear = clr;
    checkOutput("chk_valid_c2", 32'(chk_valid_2), 32'd1);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0);
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    logic       exp_v;

    // Reset state of both instances.
    doReset();
    checkOutput("rst_chk_valid2", 32'(chk_valid_2), 32'd0);
    checkOutput("rst_mismatch2",  32'(mismatch_2),  32'd0);
    checkOutput("rst_sticky2",    32'(sticky_2),    32'd0);
    checkOutput("rst_err2",       32'(err_count_2), 32'd0);
    checkOutput("rst_chk2",       chk_count_2,      32'd0);
    checkOutput("rst_fexp2",      32'(first_exp_2), 32'd0);
    checkOutput("rst_fgot2",      32'(first_got_2), 32'd0);
    checkOutput("rst_chk_valid3", 32'(chk_valid_3), 32'd0);
    checkOutput("rst_mismatch3",  32'(mismatch_3),  32'd0);
    checkOutput("rst_sticky3",    32'(sticky_3),    32'd0);
    checkOutput("rst_err3",       32'(err_count_3), 32'd0);
    checkOutput("rst_chk3",       chk_count_3,      32'd0);
    checkOutput("rst_fexp3",      32'(first_exp_3), 32'd0);
    checkOutput("rst_fgot3",      32'(first_got_3), 32'd0);

    // 3*5 & FFFF = 15, good result.
    runOne(16'd3, 16'd5, 16'hFFFF, 16'd15, 1'b0);
    checkOutput("pass_mismatch", 32'(mismatch_2),  32'd0);
    checkOutput("pass_chk",      chk_count_2,      32'd1);
    checkOutput("pass_sticky",   32'(sticky_2),    32'd0);

    // 0x100*0x100 truncates to 0.
    runOne(16'h0100, 16'h0100, 16'hFFFF, 16'h0000, 1'b0);
    checkOutput("trunc_mismatch", 32'(mismatch_2),  32'd0);
    checkOutput("trunc_chk",      chk_count_2,      32'd2);
    checkOutput("trunc_err",      32'(err_count_2), 32'd0);

    // 15 & 0xE = 0xE, DUT returns 0xF.
    runOne(16'd3, 16'd5, 16'h000E, 16'h000F, 1'b0);
    checkOutput("bad1_mismatch", 32'(mismatch_2),  32'd1);
    checkOutput("bad1_sticky",   32'(sticky_2),    32'd1);
    checkOutput("bad1_err",      32'(err_count_2), 32'd1);
    checkOutput("bad1_chk",      chk_count_2,      32'd3);
    checkOutput("bad1_fexp",     32'(first_exp_2), 32'h000E);
    checkOutput("bad1_fgot",     32'(first_got_2), 32'h000F);
    tick();
    checkOutput("bad1_pulse_end", 32'(mismatch_2), 32'd0);

    // Second bad result (expected 4, got 7) keeps the first capture.
    runOne(16'd2, 16'd2, 16'hFFFF, 16'd7, 1'b0);
    checkOutput("bad2_mismatch", 32'(mismatch_2),  32'd1);
    checkOutput("bad2_err",      32'(err_count_2), 32'd2);
    checkOutput("bad2_fexp",     32'(first_exp_2), 32'h000E);
    checkOutput("bad2_fgot",     32'(first_got_2), 32'h000F);

    // Clear coincident with a mismatch: nothing counted or captured.
    runOne(16'd3, 16'd5, 16'hFFFF, 16'd0, 1'b1);
    checkOutput("clrcoin_err",    32'(err_count_2), 32'd0);
    checkOutput("clrcoin_chk",    chk_count_2,      32'd0);
    checkOutput("clrcoin_sticky", 32'(sticky_2),    32'd0);
    checkOutput("clrcoin_fexp",   32'(first_exp_2), 32'd0);
    checkOutput("clrcoin_fgot",   32'(first_got_2), 32'd0);

    // Clear mid-stream: checks at cycles 2..5, clear at 3 drops the first two.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 4, 16'd3, 16'd5, 16'hFFFF, 16'd15);
      clear = (i == 3);
      tick();
    end
    clear = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("clrrun_chk",    chk_count_2,      32'd2);
    checkOutput("clrrun_err",    32'(err_count_2), 32'd0);
    checkOutput("clrrun_sticky", 32'(sticky_2),    32'd0);

    // Reset one cycle after the operand kills the check.
    doReset();
    applyStimulus(1'b1, 16'd3, 16'd5, 16'hFFFF, '0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p   = 16'h1234;
    checkOutput("rstkill_chk_valid", 32'(chk_valid_2), 32'd0);
    tick();
    p = '0;
    checkOutput("rstkill_mismatch", 32'(mismatch_2),  32'd0);
    checkOutput("rstkill_err",      32'(err_count_2), 32'd0);
    checkOutput("rstkill_chk",      chk_count_2,      32'd0);
    checkOutput("rstkill_sticky",   32'(sticky_2),    32'd0);

    // Valid pattern 1,0,1,1 (cycle 0 first) with p always correct.
    doReset();
    pat = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i < 4) ? pat[i] : 1'b0, 16'd1, 16'd1, 16'hFFFF, 16'd1);
      exp_v = (i >= 3 && i <= 6) ? pat[i-3] : 1'b0;
      checkOutput($sformatf("gap3_c%0d", i), 32'(chk_valid_3), 32'(exp_v));
      exp_v = (i >= 2 && i <= 5) ? pat[i-2] : 1'b0;
      checkOutput($sformatf("gap2_c%0d", i), 32'(chk_valid_2), 32'(exp_v));
      tick();
    end
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("gap2_chk", chk_count_2,      32'd3);
    checkOutput("gap2_err", 32'(err_count_2), 32'd0);

    // 70000 back-to-back bad results: expected 1, p held at 0.
    doReset();
    applyStimulus(1'b1, 16'd1, 16'd1, 16'hFFFF, 16'd0);
    repeat (70000) tick();
    applyStimulus(1'b0, '0, '0, '0, '0);
    repeat (4) tick();
    checkOutput("sat_err",    32'(err_count_2), 32'h0000FFFF);
    checkOutput("sat_chk",    chk_count_2,      32'd70000);
    checkOutput("sat_sticky", 32'(sticky_2),    32'd1);
    checkOutput("sat_fexp",   32'(first_exp_2), 32'd1);
    checkOutput("sat_fgot",   32'(first_got_2), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_err",    32'(err_count_2), 32'd0);
    checkOutput("clr_chk",    chk_count_2,      32'd0);
    checkOutput("clr_sticky", 32'(sticky_2),    32'd0);
    runOne(16'd3, 16'd5, 16'hFFFF, 16'd0, 1'b0);
    checkOutput("postclr_err",  32'(err_count_2), 32'd1);
    checkOutput("postclr_chk",  chk_count_2,      32'd1);
    checkOutput("postclr_fexp", 32'(first_exp_2), 32'h000F);
    checkOutput("postclr_fgot", 32'(first_got_2), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
